// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
//   FQ_NOP              : instruction presented to decode when nothing is valid
//   FQ_DEFAULT_RESET_PC : default first fetch address after reset
//   FQ_DEFAULT_DEPTH    : default number of queue entries
//   fq_entry_t          : one queued {address, instruction} pair
package fetch_queue_pkg;

  localparam logic [31:0] FQ_NOP              = 32'h0000_0000;
  localparam logic [31:0] FQ_DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned FQ_DEFAULT_DEPTH    = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {address, instruction} entries.
// All state updates on the falling clock edge.
//   clk, reset      : clock, synchronous active-high reset
//   flush           : empties the FIFO; dominates push and pop
//   push, push_data : write one entry at the tail
//   pop             : drop the head entry (ignored when empty)
//   head            : entry at the head of the FIFO
//   empty, count    : occupancy status
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEFAULT_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  fq_entry_t       push_data,
  input  logic            pop,
  output fq_entry_t       head,
  output logic            empty,
  output logic [CW-1:0]   count
);

  fq_entry_t         mem_q [DEPTH];
  fq_entry_t         mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !flush;
  assign pop_ok  = pop && !flush && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(negedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches to instruction
// memory, queues the one-cycle-latency responses and presents the oldest one
// to decode. A decode redirect flushes the queue and restarts fetch.
// All state updates on the falling clock edge.
//   clk, reset                : clock, synchronous active-high reset
//   imem_req, imem_addr       : fetch request and word-aligned address
//   imem_rdata                : instruction returned one cycle after request
//   stall_id                  : decode cannot accept the head this cycle
//   redirect, redirect_pc     : taken branch/jump and its target
//   inst_id, pc_plus_four_id  : head instruction and its address + 4
//   inst_valid_id             : head outputs are meaningful
//   queue_count               : occupied queue entries
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_DEFAULT_RESET_PC,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          stall_id,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic [31:0]   inst_id,
  output logic [31:0]   pc_plus_four_id,
  output logic          inst_valid_id,
  output logic [CW-1:0] queue_count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two of at least 2");
  end

  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_addr_q, inflight_addr_d;

  logic          fifo_flush, fifo_push, fifo_pop, fifo_empty;
  fq_entry_t     fifo_head, fifo_push_data;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;

  // Counting the in-flight response against capacity means a granted
  // request always has a free slot when its data returns.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign imem_req  = !reset && !redirect && (occupancy < DEPTH_L);
  assign imem_addr = fetch_pc_q;

  assign inst_valid_id   = !reset && !fifo_empty;
  assign inst_id         = inst_valid_id ? fifo_head.inst : FQ_NOP;
  assign pc_plus_four_id = inst_valid_id ? fifo_head.addr + 32'd4 : '0;
  assign queue_count     = reset ? '0 : fifo_count;

  // Reset and redirect both discard queued and returning instructions.
  assign fifo_flush          = reset || redirect;
  assign fifo_push           = inflight_q;
  assign fifo_pop            = inst_valid_id && !stall_id;
  assign fifo_push_data.addr = inflight_addr_q;
  assign fifo_push_data.inst = imem_rdata;

  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = imem_req;
    inflight_addr_d = inflight_addr_q;
    if (reset) begin
      fetch_pc_d = RESET_PC;
    end else if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (imem_req) begin
      fetch_pc_d      = fetch_pc_q + 32'd4;
      inflight_addr_d = fetch_pc_q;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      fetch_pc_q      <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0).
// Memory returns the requested address as the instruction word.
module tb_fetch_queue;

  logic        clk = 1'b1;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_id;
  logic [31:0] pc_plus_four_id;
  logic        inst_valid_id;
  logic [2:0]  queue_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall_id        (stall_id),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .inst_id         (inst_id),
    .pc_plus_four_id (pc_plus_four_id),
    .inst_valid_id   (inst_valid_id),
    .queue_count     (queue_count)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memory: data for a request appears the next cycle.
  always @(negedge clk) imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},   32'(imem_req), 32'd0);
    chk({tag, " valid"}, 32'(inst_valid_id), 32'd0);
    chk({tag, " inst"},  inst_id, 32'd0);
    chk({tag, " ppf"},   pc_plus_four_id, 32'd0);
    chk({tag, " count"}, 32'(queue_count), 32'd0);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, " valid"}, 32'(inst_valid_id), 32'd1);
    chk({tag, " inst"},  inst_id, pc);
    chk({tag, " ppf"},   pc_plus_four_id, pc + 32'd4);
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr);
    chk({tag, " req"},  32'(imem_req), 32'd1);
    chk({tag, " addr"}, imem_addr, addr);
  endtask

  initial begin
    reset = 1'b1; stall_id = 1'b0; redirect = 1'b0; redirect_pc = '0;
    next(); #1;
    chk_reset_outputs("in_reset");
    next();
    reset = 1'b0;

    // Sequential fetch after reset release (cycle k fetches 4k).
    for (int k = 0; k < 6; k++) begin
      #1;
      chk_fetch($sformatf("seq%0d", k), 32'(4 * k));
      if (k < 2) begin
        chk($sformatf("seq%0d valid", k), 32'(inst_valid_id), 32'd0);
      end else begin
        chk_head($sformatf("seq%0d", k), 32'(4 * (k - 2)));
        chk($sformatf("seq%0d count", k), 32'(queue_count), 32'd1);
      end
      next();
    end

    // Stall for 10 cycles: queue fills to 4, head stays at 16.
    for (int k = 6; k < 16; k++) begin
      stall_id = 1'b1;
      #1;
      chk_head($sformatf("stall%0d", k), 32'd16);
      if (k == 6) chk_fetch("stall6", 32'd24);
      if (k == 7) chk_fetch("stall7", 32'd28);
      if (k >= 8) chk($sformatf("stall%0d req", k), 32'(imem_req), 32'd0);
      if (k >= 9) chk($sformatf("stall%0d count", k), 32'(queue_count), 32'd4);
      next();
    end

    // Release: drain in address order.
    for (int k = 16; k < 20; k++) begin
      stall_id = 1'b0;
      #1;
      chk_head($sformatf("drain%0d", k), 32'(16 + 4 * (k - 16)));
      chk($sformatf("drain%0d count", k), 32'(queue_count), (k == 16) ? 32'd4 : (k == 17) ? 32'd3 : 32'd2);
      next();
    end

    // Build 3 queued entries with one response in flight.
    stall_id = 1'b1;
    #1;
    chk_head("fill20", 32'd32);
    chk_fetch("fill20", 32'd44);
    next();

    // Redirect to 0x100 with 3 queued and 44 in flight.
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("rd21 count", 32'(queue_count), 32'd3);
    chk("rd21 req", 32'(imem_req), 32'd0);
    next();
    redirect = 1'b0; stall_id = 1'b0;
    #1;
    chk("rd22 count", 32'(queue_count), 32'd0);
    chk("rd22 valid", 32'(inst_valid_id), 32'd0);
    chk("rd22 inst", inst_id, 32'd0);
    chk_fetch("rd22", 32'h100);
    next(); #1;
    chk("rd23 valid", 32'(inst_valid_id), 32'd0);
    chk_fetch("rd23", 32'h104);
    next(); #1;
    chk_head("rd24", 32'h100);
    chk("rd24 count", 32'(queue_count), 32'd1);

    // Redirect together with stall; misaligned target.
    redirect = 1'b1; stall_id = 1'b1; redirect_pc = 32'h203;
    #1;
    chk("rs24 req", 32'(imem_req), 32'd0);
    next();
    redirect = 1'b0; stall_id = 1'b0;
    #1;
    chk_fetch("rs25", 32'h200);
    chk("rs25 valid", 32'(inst_valid_id), 32'd0);
    chk("rs25 count", 32'(queue_count), 32'd0);
    next(); #1;
    chk_fetch("rs26", 32'h204);
    chk("rs26 valid", 32'(inst_valid_id), 32'd0);
    next(); #1;
    chk_head("rs27", 32'h200);

    // Redirect near the top of the address space: wrap to 0.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    next();
    redirect = 1'b0;
    #1;
    chk_fetch("wr28", 32'hFFFF_FFF8);
    next(); #1;
    chk_fetch("wr29", 32'hFFFF_FFFC);
    next(); #1;
    chk_fetch("wr30", 32'h0);
    chk_head("wr30", 32'hFFFF_FFF8);
    next(); #1;
    chk_fetch("wr31", 32'h4);
    chk_head("wr31", 32'hFFFF_FFFC);
    chk("wr31 ppf_wrap", pc_plus_four_id, 32'h0);
    next();

    // Fill with a response in flight, then pulse reset for one cycle.
    stall_id = 1'b1;
    #1;
    chk_head("rp32", 32'h0);
    chk_fetch("rp32", 32'h8);
    chk("rp32 count", 32'(queue_count), 32'd1);
    next(); #1;
    chk_fetch("rp33", 32'hC);
    chk("rp33 count", 32'(queue_count), 32'd2);
    next(); #1;
    chk("rp34 count", 32'(queue_count), 32'd3);
    chk("rp34 req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rp34_reset");
    next();
    reset = 1'b0; stall_id = 1'b0;
    #1;
    chk_fetch("rp35", 32'h0);
    chk("rp35 valid", 32'(inst_valid_id), 32'd0);
    chk("rp35 count", 32'(queue_count), 32'd0);
    next(); #1;
    chk_fetch("rp36", 32'h4);
    chk("rp36 valid", 32'(inst_valid_id), 32'd0);
    next(); #1;
    chk_head("rp37", 32'h0);
    chk("rp37 count", 32'(queue_count), 32'd1);
    next(); #1;
    chk_head("rp38", 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
